// File: rtl/udp_bridge_core_pio_in.sv
// Avalon-MM input PIO: synchronizes external pins, captures selected edges into a sticky
// register and raises a maskable level interrupt.
module udp_bridge_core_pio_in #(
   parameter int unsigned WIDTH       = 2,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned PrimeMax = SYNC_STAGES + 1;
   localparam int unsigned CntW     = $clog2(PrimeMax + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  mask_q, mask_d;
   logic [WIDTH-1:0]                  cap_q, cap_d;
   logic [CntW-1:0]                   prime_cnt_q, prime_cnt_d;

   logic             wr;
   logic             primed;
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr;
   logic             unused_wd;

   assign wr        = chipselect & ~write_n;
   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign primed    = (prime_cnt_q == CntW'(PrimeMax));
   assign unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= '0;
         prev_q      <= '0;
         mask_q      <= '0;
         cap_q       <= '0;
         prime_cnt_q <= '0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= sync_out;
         mask_q      <= mask_d;
         cap_q       <= cap_d;
         prime_cnt_q <= prime_cnt_d;
      end
   end

   always_comb begin
      if (SYNC_STAGES > 1) begin
         sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
      end else begin
         sync_d = in_port;
      end
   end

   // Hold off edge detection until the synchronizer and prev have been filled with real samples.
   always_comb begin
      prime_cnt_d = prime_cnt_q;
      if (!primed) begin
         prime_cnt_d = prime_cnt_q + CntW'(1);
      end
   end

   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_det = sync_out & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_det = ~sync_out & prev_q;
      end else begin
         edge_det = sync_out ^ prev_q;
      end
      if (!primed) begin
         edge_det = '0;
      end
   end

   always_comb begin
      clr    = '0;
      mask_d = mask_q;
      if (wr && (address == 2'd3)) begin
         clr = writedata[WIDTH-1:0];
      end
      if (wr && (address == 2'd2)) begin
         mask_d = writedata[WIDTH-1:0];
      end
      // A new edge wins over a simultaneous clear so no event is lost.
      cap_d = (cap_q & ~clr) | edge_det;
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         2'd0:    readdata = 32'(sync_out);
         2'd1:    readdata = '0;
         2'd2:    readdata = 32'(mask_q);
         2'd3:    readdata = 32'(cap_q);
         default: readdata = '0;
      endcase
   end

   assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_udp_bridge_core_pio_in.sv
// Scoreboard bench for the input PIO: three instances (rising, falling, any edge) share stimulus;
// expectations come from a pin-history model and are popped by a negedge monitor.
module tb_udp_bridge_core_pio_in;

   localparam int unsigned S = 2;
   localparam int unsigned N = 3;

   typedef struct packed {
      logic [15:0]           id;
      logic [1:0]            addr;
      logic [N-1:0][31:0]    rd;
      logic [N-1:0]          irq;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [1:0]  in_port;
   logic [31:0] rdata [N];
   logic        irq_w [N];

   logic        rd_valid;
   exp_t        sb [$];
   int          total;
   int          bad;
   logic [15:0] next_id;

   // Reference model state: raw pin samples taken at each clock, newest first.
   logic [1:0]  hist [0:S];
   logic [1:0]  m_cap [N];
   logic [1:0]  m_mask;
   int          edges_since_rel;

   udp_bridge_core_pio_in #(.WIDTH(2), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[0]), .irq(irq_w[0])
   );
   udp_bridge_core_pio_in #(.WIDTH(2), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[1]), .irq(irq_w[1])
   );
   udp_bridge_core_pio_in #(.WIDTH(2), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[2]), .irq(irq_w[2])
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i <= S; i++) hist[i] = '0;
      for (int t = 0; t < N; t++) m_cap[t] = '0;
      m_mask = '0;
      edges_since_rel = 0;
   endtask

   // One clock of the bus-visible behaviour, computed from the pin history.
   task automatic model_step();
      logic [1:0] lvl, old, ev, clr;
      lvl = hist[S-1];
      old = hist[S];
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[1:0] : 2'b00;
      for (int t = 0; t < N; t++) begin
         case (t)
            0:       ev = lvl & ~old;
            1:       ev = ~lvl & old;
            default: ev = lvl ^ old;
         endcase
         if (edges_since_rel < S + 1) ev = 2'b00;
         m_cap[t] = (m_cap[t] & ~clr) | ev;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
      edges_since_rel++;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      rd_valid   = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_read(input logic [1:0] a);
      exp_t e;
      address = a;
      e.id    = next_id;
      e.addr  = a;
      for (int t = 0; t < N; t++) begin
         case (a)
            2'd0:    e.rd[t] = {30'd0, hist[S-1]};
            2'd2:    e.rd[t] = {30'd0, m_mask};
            2'd3:    e.rd[t] = {30'd0, m_cap[t]};
            default: e.rd[t] = 32'd0;
         endcase
         e.irq[t] = |(m_cap[t] & m_mask);
      end
      sb.push_back(e);
      next_id++;
      rd_valid = 1'b1;
   endtask

   task automatic do_read_zero(input logic [1:0] a);
      exp_t e;
      address = a;
      e.id    = next_id;
      e.addr  = a;
      e.rd    = '0;
      e.irq   = '0;
      sb.push_back(e);
      next_id++;
      rd_valid = 1'b1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
   endtask

   task automatic read_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do_read(2'(i % 4));
         tick();
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: read presented with no expectation queued");
         end else begin
            exp_t e;
            e = sb.pop_front();
            for (int t = 0; t < N; t++) begin
               total++;
               if (rdata[t] !== e.rd[t] || irq_w[t] !== e.irq[t]) begin
                  bad++;
                  $display("FAIL read%0d inst%0d addr%0d: got rd=%h irq=%b, want rd=%h irq=%b",
                           e.id, t, e.addr, rdata[t], irq_w[t], e.rd[t], e.irq[t]);
               end
            end
         end
      end
   end

   initial begin
      clk        = 1'b0;
      reset_n    = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 2'b11;
      rd_valid   = 1'b0;
      total      = 0;
      bad        = 0;
      next_id    = '0;
      model_reset();
      #2 reset_n = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) begin
         do_read_zero(2'(a));
         tick();
      end

      // Pins already high at release must not produce a capture.
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         do_read((i % 2 == 0) ? 2'd3 : 2'd0);
         tick();
      end

      in_port = 2'b00;
      read_ticks(4);
      do_write(2'd2, 32'h1);
      tick();
      in_port = 2'b01;
      read_ticks(6);
      in_port = 2'b11;
      read_ticks(6);
      do_write(2'd3, 32'h1);
      tick();
      do_read(2'd3);
      tick();

      // Clear of bit1 landing on the same edge as a new bit1 rise.
      in_port = 2'b01;
      read_ticks(5);
      in_port = 2'b11;
      do_read(2'd0);
      tick();
      do_read(2'd0);
      tick();
      do_write(2'd3, 32'h2);
      tick();
      do_read(2'd3);
      tick();

      do_write(2'd2, 32'h1);
      tick();
      do_read(2'd3);
      tick();
      do_write(2'd2, 32'h3);
      tick();
      do_read(2'd3);
      tick();
      do_write(2'd2, 32'h0);
      tick();
      do_read(2'd3);
      tick();
      do_read(2'd2);
      tick();
      do_write(2'd0, 32'hffff_ffff);
      tick();
      do_write(2'd1, 32'hffff_ffff);
      tick();
      read_ticks(4);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) in_port = 2'($urandom);
         if ($urandom_range(0, 3) == 0) do_write(2'($urandom_range(0, 3)), $urandom);
         else do_read(2'($urandom_range(0, 3)));
         tick();
      end

      // Load everything, then drop reset between clock edges.
      do_write(2'd2, 32'h3);
      tick();
      in_port = 2'b00;
      read_ticks(5);
      in_port = 2'b11;
      read_ticks(5);
      in_port = 2'b00;
      read_ticks(5);
      reset_n = 1'b0;
      model_reset();
      for (int a = 0; a < 4; a++) begin
         do_read_zero(2'(a));
         tick();
      end
      reset_n = 1'b1;
      in_port = 2'b10;
      read_ticks(12);

      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/udp_bridge_core_pio_in.md
Name: udp_bridge_core_pio_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the bridge's output PIO.
- Samples external status pins into the clk domain and exposes their level to the bus master.
- Latches selected edges into a sticky edge-capture register.
- Raises a maskable level interrupt.
- Sits on the udp_bridge_core interconnect next to the output PIO and uses the same register-map style.

Parameters:
- WIDTH, 2, number of input pins (1..32).
- EDGE_TYPE, 0, edge to capture: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, synchronizer flops per pin (2..3).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset; all flops clear on assertion, release is synchronous to clk.
- address  input  2  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH are ignored.
- in_port  input  WIDTH  asynchronous external pins.
- readdata  output  32  read data, zero-extended.
- irq  output  1  level interrupt, active high.

Behaviour:
- Register map:
  - addr0: DATA, read-only, synchronized pin level.
  - addr1: reserved, reads 0, writes ignored.
  - addr2: IRQMASK, R/W, WIDTH bits.
  - addr3: EDGECAP, read returns the sticky bits; a write clears every bit where writedata is 1.
- Write strobe: wr = chipselect & ~write_n. There is no waitrequest, so every access completes in the cycle it is presented.
- Read: readdata is combinational from address, with zero read latency and no side effects. readdata is valid whenever address is stable; chipselect is not required for reads.
- Synchronizer: sync[0..SYNC_STAGES-1] shift in_port every clk.
  - sync_out = last stage.
  - prev = sync_out delayed one clk.
- Latency, with in_port changing before edge k:
  - DATA reflects the new value after edge k+SYNC_STAGES-1.
  - The matching EDGECAP bit sets at edge k+SYNC_STAGES.
  - irq follows combinationally from the registers, so it is high in the same cycle as the EDGECAP bit.
- Edge detect, per bit:
  - EDGE_TYPE 0: sync_out & ~prev.
  - EDGE_TYPE 1: ~sync_out & prev.
  - EDGE_TYPE 2: sync_out ^ prev.
- Reset priming: a counter prime_cnt counts SYNC_STAGES+1 clks after reset release.
  - Edge detection is gated off until the count completes.
  - A pin already high at reset release therefore never produces a spurious rising capture.
  - The counter saturates and stays saturated until the next reset.
- EDGECAP update per bit: next = (cap & ~clr) | edge, where clr = wr & (address==3) & writedata[i].
  - If a clear and a new edge land in the same cycle, set wins; the bit stays 1 and the event is not lost.
  - Repeated edges while the bit is already set are absorbed; there is no counting.
- IRQMASK: loaded on wr & (address==2).
- irq = |(EDGECAP & IRQMASK).
  - Masking a pending bit drops irq the next cycle without clearing EDGECAP.
  - Unmasking a pending bit raises irq the next cycle.
- Writes to addr0 or addr1 have no effect.
- Reset values (immediate on reset_n low, including mid-operation):
  - sync, prev, prime_cnt, IRQMASK, EDGECAP all 0.
  - irq 0.
  - readdata 0 for every address.
- Bits [31:WIDTH] of readdata are always 0.

Test Plan:
- Reset release with in_port=2'b11 held high, EDGE_TYPE=0 -> EDGECAP stays 0 and irq stays 0 for 20 clks; DATA reads 0x3 from edge SYNC_STAGES-1 after release onward.
- in_port[0] 0->1 before edge k, IRQMASK=0x1 -> DATA=0x1 after edge k+1; EDGECAP=0x1 and irq=1 after edge k+2 (SYNC_STAGES=2).
- With EDGECAP=0x3, write 0x1 to addr3 -> EDGECAP reads 0x2. Then write 0x2 in the same cycle a new bit1 edge is detected -> EDGECAP stays 0x2 (set wins).
- EDGECAP=0x2 with IRQMASK=0x1 -> irq=0. Write IRQMASK=0x3 -> irq=1 the next cycle. Write IRQMASK=0 -> irq=0 and EDGECAP still 0x2.
- EDGE_TYPE=2, toggle in_port[1] 1->0 -> EDGECAP bit1 sets. With EDGE_TYPE=0, the same stimulus -> EDGECAP stays 0.
- Assert reset_n low mid-operation with EDGECAP=0x3, IRQMASK=0x3 -> irq, EDGECAP and IRQMASK clear immediately; reads of addr0..3 return 0x00000000 during reset.
